// File: rtl/cpu_mem_pkg.sv
// Shared types and lane-order helpers for the CPU memory access path.
package cpu_mem_pkg;

    // Bit 2 of the opcode marks a store.
    typedef enum logic [2:0] {
        LW = 3'd0,
        LH = 3'd1,
        LB = 3'd2,
        SW = 3'd4,
        SH = 3'd5,
        SB = 3'd6
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WRITE,
        RESP
    } mac_state_t;

    // Big-endian lanes: offset 0 lives in the most significant bits.
    localparam logic [4:0] BYTE0_LSB = 5'd24;
    localparam logic [4:0] HALF0_LSB = 5'd16;

    function automatic logic [4:0] byte_lsb(input logic [1:0] off);
        return BYTE0_LSB - {off, 3'b000};
    endfunction

    function automatic logic [4:0] half_lsb(input logic off);
        return HALF0_LSB - {off, 4'b0000};
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load extract/sign-extend, sub-word store merge,
// and alignment check for a request about to be accepted.
module mem_lane_unit
    import cpu_mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  mem_op_t     chk_op,
    input  logic [1:0]  chk_off,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane and sign-extend it for sub-word loads.
    always_comb begin
        lane_b = word[byte_lsb(off) +: 8];
        lane_h = word[half_lsb(off[1]) +: 16];
        case (op)
            LH:      load_val = {{16{lane_h[15]}}, lane_h};
            LB:      load_val = {{24{lane_b[7]}}, lane_b};
            default: load_val = word;
        endcase
    end

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        merged = word;
        case (op)
            SH:      merged[half_lsb(off[1]) +: 16] = wdata[15:0];
            SB:      merged[byte_lsb(off) +: 8]     = wdata[7:0];
            default: ;
        endcase
    end

    // Word accesses need a 4-byte boundary, halfword accesses a 2-byte one.
    always_comb begin
        case (chk_op)
            LW, SW:  misaligned = (chk_off != 2'b00);
            LH, SH:  misaligned = chk_off[0];
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter for the single shared memory port: data requests beat
// fetches, sub-word stores are done as read-modify-write.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              dm_req,
    input  logic [2:0]        dm_op,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    mac_state_t        state;
    logic [1:0]        cnt;
    mem_op_t           op_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic              fetch_q;

    mem_op_t           acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              misaligned;

    // Request presented for acceptance this cycle: data has priority, a fetch is a plain LW.
    always_comb begin
        acc_op   = dm_req ? mem_op_t'(dm_op) : LW;
        acc_addr = dm_req ? dm_addr : if_addr;
    end

    assign busy = (state != IDLE);

    mem_lane_unit u_lane (
        .op         (op_q),
        .off        (off_q),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .chk_op     (acc_op),
        .chk_off    (acc_addr[1:0]),
        .load_val   (load_val),
        .merged     (merged),
        .misaligned (misaligned)
    );

    // Main FSM; every output is set on entry to the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= LW;
            off_q     <= '0;
            wdata_q   <= '0;
            fetch_q   <= 1'b0;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            mem_wr  <= 1'b0;
            case (state)
                IDLE: begin
                    err <= 1'b0;
                    if (dm_req || if_req) begin
                        op_q     <= acc_op;
                        off_q    <= acc_addr[1:0];
                        wdata_q  <= dm_wdata;
                        fetch_q  <= !dm_req;
                        mem_addr <= {acc_addr[ADDR_W-1:2], 2'b00};
                        cnt      <= 2'(MEM_LAT - 1);
                        if (misaligned) begin
                            state   <= RESP;
                            rdata   <= '0;
                            err     <= dm_req;
                            dm_done <= dm_req;
                            if_done <= !dm_req;
                        end else if (acc_op == SW) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= dm_wdata;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 2'd0) begin
                        if (op_q[2]) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= merged;
                        end else begin
                            state   <= RESP;
                            rdata   <= load_val;
                            err     <= 1'b0;
                            if_done <= fetch_q;
                            dm_done <= !fetch_q;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                WRITE: begin
                    state   <= RESP;
                    rdata   <= '0;
                    err     <= 1'b0;
                    dm_done <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
